// File: rtl/imem_loader.sv
// imem_loader
//   Writer side of the instruction memory. Takes a byte stream (valid/ready) made of
//   LEN, N x {lo,hi}, CSUM. It assembles 16-bit instructions low byte first and writes
//   them to consecutive 8-bit addresses starting at START_ADDR. The CPU is held stalled
//   for the whole load, and the load is checked against an XOR checksum at the end.
//
//   Ports:
//     clk        posedge clock
//     reset      asynchronous, active-high reset
//     start      begin a load (honoured only in IDLE, DONE, ERR)
//     in_valid   byte source has a byte
//     in_data    byte from source
//     in_ready   loader accepts a byte; transfer = in_valid & in_ready
//     mem_we     one-cycle write pulse to the instruction memory
//     mem_addr   write address (holds its last value)
//     mem_wdata  write data {hi,lo} (holds its last value)
//     cpu_hold   CPU/PC stall while a load is in progress
//     load_done  load finished with a good checksum (level)
//     load_err   checksum mismatch or timeout (level)
//
//   state | meaning
//   ------+----------------------------------------------------
//   IDLE  | after reset, waiting for start
//   LEN   | waiting for the instruction-count byte (0 = 256)
//   LO    | waiting for the low byte of the next instruction
//   HI    | waiting for the high byte of the next instruction
//   WRITE | single-cycle memory write, no byte accepted
//   CSUM  | waiting for the checksum byte
//   DONE  | load good; flag held until start or reset
//   ERR   | bad checksum or timeout; flag held until start or reset

module imem_loader #(
    parameter logic [7:0] START_ADDR = 8'h00,
    parameter int         TIMEOUT    = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [15:0] mem_wdata,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_err
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN   = 3'd1;
    localparam logic [2:0] S_LO    = 3'd2;
    localparam logic [2:0] S_HI    = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_CSUM  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;
    localparam logic [2:0] S_ERR   = 3'd7;

    logic [2:0]    state_q, state_d;
    logic [7:0]    count_q, count_d;
    logic [7:0]    idx_q, idx_d;
    logic [7:0]    csum_q, csum_d;
    logic [7:0]    lo_q, lo_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          in_ready_q, in_ready_d;
    logic          mem_we_q, mem_we_d;
    logic [7:0]    mem_addr_q, mem_addr_d;
    logic [15:0]   mem_wdata_q, mem_wdata_d;
    logic          cpu_hold_q, cpu_hold_d;
    logic          load_done_q, load_done_d;
    logic          load_err_q, load_err_d;
    logic          xfer;

    // in_ready_q is high exactly in the byte-waiting states, so it doubles as the
    // "timer is running" qualifier.
    assign xfer = in_valid & in_ready_q;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        idx_d       = idx_q;
        csum_d      = csum_q;
        lo_d        = lo_q;
        timer_d     = timer_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        load_done_d = load_done_q;
        load_err_d  = load_err_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d     = S_LEN;
                    load_done_d = 1'b0;
                    load_err_d  = 1'b0;
                    idx_d       = 8'd0;
                    csum_d      = 8'd0;
                    timer_d     = '0;
                end
            end
            S_LEN: begin
                if (xfer) begin
                    count_d = in_data;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (xfer) begin
                    lo_d    = in_data;
                    csum_d  = csum_q ^ in_data;
                    state_d = S_HI;
                end
            end
            S_HI: begin
                // Address and data are loaded here so they are registered and
                // valid in the same cycle as the mem_we pulse.
                if (xfer) begin
                    mem_wdata_d = {in_data, lo_q};
                    mem_addr_d  = START_ADDR + idx_q;
                    csum_d      = csum_q ^ in_data;
                    state_d     = S_WRITE;
                end
            end
            S_WRITE: begin
                // count of 0 means 256 instructions: count-1 wraps to 255.
                if (idx_q == count_q - 8'd1) begin
                    state_d = S_CSUM;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = S_LO;
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    if (in_data == csum_q) begin
                        state_d     = S_DONE;
                        load_done_d = 1'b1;
                    end else begin
                        state_d    = S_ERR;
                        load_err_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (in_ready_q) begin
            if (xfer) begin
                timer_d = '0;
            end else if (timer_q == TIMER_LAST) begin
                state_d    = S_ERR;
                load_err_d = 1'b1;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end

        in_ready_d = (state_d == S_LEN) || (state_d == S_LO) ||
                     (state_d == S_HI)  || (state_d == S_CSUM);
        cpu_hold_d = in_ready_d || (state_d == S_WRITE);
        mem_we_d   = (state_d == S_WRITE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            count_q     <= 8'd0;
            idx_q       <= 8'd0;
            csum_q      <= 8'd0;
            lo_q        <= 8'd0;
            timer_q     <= '0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 8'd0;
            mem_wdata_q <= 16'd0;
            cpu_hold_q  <= 1'b0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            csum_q      <= csum_d;
            lo_q        <= lo_d;
            timer_q     <= timer_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign load_done = load_done_q;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader. Two instances share the byte stream: dut0 with
// START_ADDR 0, dut1 with START_ADDR FF (address wrap). TIMEOUT is 16 for both.
module tb_imem_loader;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;

    logic        in_ready0, mem_we0, cpu_hold0, load_done0, load_err0;
    logic [7:0]  mem_addr0;
    logic [15:0] mem_wdata0;
    logic        in_ready1, mem_we1, cpu_hold1, load_done1, load_err1;
    logic [7:0]  mem_addr1;
    logic [15:0] mem_wdata1;

    int errors = 0;
    int checks = 0;

    logic [7:0]  wa0[$];
    logic [15:0] wd0[$];
    logic [7:0]  wa1[$];
    logic [15:0] wd1[$];

    imem_loader #(.START_ADDR(8'h00), .TIMEOUT(TMO)) dut0 (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
        .cpu_hold(cpu_hold0), .load_done(load_done0), .load_err(load_err0)
    );

    imem_loader #(.START_ADDR(8'hFF), .TIMEOUT(TMO)) dut1 (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .cpu_hold(cpu_hold1), .load_done(load_done1), .load_err(load_err1)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we0) begin
            wa0.push_back(mem_addr0);
            wd0.push_back(mem_wdata0);
        end
        if (mem_we1) begin
            wa1.push_back(mem_addr1);
            wd1.push_back(mem_wdata1);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        wa0.delete();
        wd0.delete();
        wa1.delete();
        wd1.delete();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Leaves in_valid high; returns just after the edge on which the byte transferred.
    task automatic send_byte(input logic [7:0] b);
        bit got;
        got = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        for (int n = 0; n < 64 && !got; n++) begin
            if (in_ready0 === 1'b1) got = 1'b1;
            tick();
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL send_byte %h: in_ready stayed 0, required 1 within 64 cycles", b);
        end
    endtask

    task automatic load2(input logic [7:0] l0, input logic [7:0] h0,
                         input logic [7:0] l1, input logic [7:0] h1, input logic [7:0] cs);
        send_byte(8'h02);
        send_byte(l0);
        send_byte(h0);
        send_byte(l1);
        send_byte(h1);
        send_byte(cs);
        in_valid = 1'b0;
    endtask

    function automatic logic [7:0] n0_hi(input int i);
        return (i < 3) ? 8'h5A : 8'h00;
    endfunction

    task automatic test_reset();
        in_valid = 1'b1;
        in_data  = 8'hAA;
        tick();
        tick();
        checks++;
        if ({in_ready0, mem_we0, mem_addr0, mem_wdata0, cpu_hold0, load_done0, load_err0} !== 29'd0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b we=%b addr=%h wd=%h hold=%b done=%b err=%b, want all 0",
                     in_ready0, mem_we0, mem_addr0, mem_wdata0, cpu_hold0, load_done0, load_err0);
        end
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if ({in_ready0, cpu_hold0, mem_we0} !== 3'b000) begin
            errors++;
            $display("FAIL idle_after_reset: got rdy=%b hold=%b we=%b, want 000", in_ready0, cpu_hold0, mem_we0);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_load_ok();
        clear_q();
        do_start();
        checks++;
        if ({cpu_hold0, in_ready0} !== 2'b11) begin
            errors++;
            $display("FAIL start_len: got hold=%b rdy=%b, want 11", cpu_hold0, in_ready0);
        end
        send_byte(8'h02);
        send_byte(8'h34);
        send_byte(8'h12);
        // WRITE cycle with in_valid still asserted
        checks++;
        if ({in_ready0, mem_we0, mem_addr0, mem_wdata0} !== {1'b0, 1'b1, 8'h00, 16'h1234}) begin
            errors++;
            $display("FAIL write_cycle: got rdy=%b we=%b addr=%h wd=%h, want rdy=0 we=1 addr=00 wd=1234",
                     in_ready0, mem_we0, mem_addr0, mem_wdata0);
        end
        send_byte(8'hCD);
        send_byte(8'hAB);
        send_byte(8'h40);
        in_valid = 1'b0;
        checks++;
        if ({load_done0, load_err0, cpu_hold0, in_ready0, mem_we0} !== 5'b10000) begin
            errors++;
            $display("FAIL load_ok_flags: got done=%b err=%b hold=%b rdy=%b we=%b, want 10000",
                     load_done0, load_err0, cpu_hold0, in_ready0, mem_we0);
        end
        checks++;
        if (wa0.size() !== 2) begin
            errors++;
            $display("FAIL load_ok_count: got %0d writes, want 2", wa0.size());
        end else begin
            checks++;
            if ({wa0[0], wd0[0], wa0[1], wd0[1]} !== {8'h00, 16'h1234, 8'h01, 16'hABCD}) begin
                errors++;
                $display("FAIL load_ok_writes: got %h:%h %h:%h, want 00:1234 01:abcd",
                         wa0[0], wd0[0], wa0[1], wd0[1]);
            end
        end
        tick();
        checks++;
        if (load_done0 !== 1'b1) begin
            errors++;
            $display("FAIL done_held: got %b want 1", load_done0);
        end
    endtask

    task automatic test_bad_csum();
        clear_q();
        do_start();
        checks++;
        if (load_done0 !== 1'b0) begin
            errors++;
            $display("FAIL start_clears_done: got %b want 0", load_done0);
        end
        load2(8'h34, 8'h12, 8'hCD, 8'hAB, 8'h41);
        checks++;
        if ({load_err0, load_done0, cpu_hold0} !== 3'b100) begin
            errors++;
            $display("FAIL bad_csum_flags: got err=%b done=%b hold=%b, want 100", load_err0, load_done0, cpu_hold0);
        end
        checks++;
        if (wd0.size() !== 2) begin
            errors++;
            $display("FAIL bad_csum_count: got %0d writes, want 2", wd0.size());
        end
    endtask

    task automatic test_wrap();
        clear_q();
        do_start();
        checks++;
        if (load_err0 !== 1'b0) begin
            errors++;
            $display("FAIL start_clears_err: got %b want 0", load_err0);
        end
        load2(8'h11, 8'h22, 8'h33, 8'h44, 8'h44);
        checks++;
        if (wa1.size() !== 2 || wa0.size() !== 2) begin
            errors++;
            $display("FAIL wrap_count: got %0d/%0d writes, want 2/2", wa1.size(), wa0.size());
        end else begin
            checks++;
            if ({wa1[0], wd1[0], wa1[1], wd1[1]} !== {8'hFF, 16'h2211, 8'h00, 16'h4433}) begin
                errors++;
                $display("FAIL wrap_writes: got %h:%h %h:%h, want ff:2211 00:4433",
                         wa1[0], wd1[0], wa1[1], wd1[1]);
            end
            checks++;
            if ({wa0[0], wa0[1]} !== {8'h00, 8'h01}) begin
                errors++;
                $display("FAIL base_addrs: got %h %h, want 00 01", wa0[0], wa0[1]);
            end
        end
        checks++;
        if ({load_done1, load_err1, in_ready1, cpu_hold1} !== 4'b1000) begin
            errors++;
            $display("FAIL wrap_flags: got done=%b err=%b rdy=%b hold=%b, want 1000",
                     load_done1, load_err1, in_ready1, cpu_hold1);
        end
    endtask

    task automatic test_n0();
        logic [7:0] cs;
        int bad;
        clear_q();
        do_start();
        cs = 8'h00;
        send_byte(8'h00);
        for (int i = 0; i < 256; i++) begin
            send_byte(8'(i));
            send_byte(n0_hi(i));
            cs = cs ^ 8'(i) ^ n0_hi(i);
        end
        // three 5A high bytes, and the low bytes 0..255 cancel out
        checks++;
        if (cs !== 8'h5A) begin
            errors++;
            $display("FAIL n0_model: got csum %h want 5a", cs);
        end
        checks++;
        if (load_done0 !== 1'b0 || cpu_hold0 !== 1'b1) begin
            errors++;
            $display("FAIL n0_before_csum: got done=%b hold=%b, want 0 1", load_done0, cpu_hold0);
        end
        send_byte(cs);
        in_valid = 1'b0;
        checks++;
        if ({load_done0, load_err0} !== 2'b10) begin
            errors++;
            $display("FAIL n0_flags: got done=%b err=%b, want 10", load_done0, load_err0);
        end
        checks++;
        if (wa0.size() !== 256) begin
            errors++;
            $display("FAIL n0_count: got %0d writes, want 256", wa0.size());
        end else begin
            bad = 0;
            for (int i = 0; i < 256; i++) begin
                if (wa0[i] !== 8'(i) || wd0[i] !== {n0_hi(i), 8'(i)}) begin
                    bad++;
                    if (bad <= 4)
                        $display("FAIL n0_write[%0d]: got %h:%h want %h:%h", i, wa0[i], wd0[i], 8'(i), {n0_hi(i), 8'(i)});
                end
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL n0_writes: got %0d bad writes, want 0", bad);
            end
        end
    endtask

    task automatic test_timeout();
        clear_q();
        do_start();
        send_byte(8'h01);
        send_byte(8'h77);
        in_valid = 1'b0;
        repeat (TMO - 1) tick();
        checks++;
        if ({load_err0, cpu_hold0} !== 2'b01) begin
            errors++;
            $display("FAIL timeout_early: got err=%b hold=%b after %0d idle, want 0 1", load_err0, cpu_hold0, TMO - 1);
        end
        tick();
        checks++;
        if ({load_err0, load_done0, cpu_hold0, in_ready0} !== 4'b1000) begin
            errors++;
            $display("FAIL timeout_err: got err=%b done=%b hold=%b rdy=%b, want 1000",
                     load_err0, load_done0, cpu_hold0, in_ready0);
        end
        checks++;
        if (wa0.size() !== 0) begin
            errors++;
            $display("FAIL timeout_no_write: got %0d writes, want 0", wa0.size());
        end
        do_start();
        load2(8'h34, 8'h12, 8'hCD, 8'hAB, 8'h40);
        checks++;
        if ({load_done0, load_err0} !== 2'b10 || wa0.size() !== 2) begin
            errors++;
            $display("FAIL timeout_recover: got done=%b err=%b writes=%0d, want 1 0 2",
                     load_done0, load_err0, wa0.size());
        end
    endtask

    task automatic test_start_ignored();
        clear_q();
        do_start();
        send_byte(8'h02);
        send_byte(8'h34);
        in_valid = 1'b0;
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        checks++;
        if ({cpu_hold0, in_ready0} !== 2'b11) begin
            errors++;
            $display("FAIL start_midload: got hold=%b rdy=%b, want 11", cpu_hold0, in_ready0);
        end
        send_byte(8'h12);
        send_byte(8'hCD);
        send_byte(8'hAB);
        send_byte(8'h40);
        in_valid = 1'b0;
        checks++;
        if (load_done0 !== 1'b1 || wa0.size() !== 2) begin
            errors++;
            $display("FAIL start_ignored_done: got done=%b writes=%0d, want 1 2", load_done0, wa0.size());
        end else begin
            checks++;
            if ({wd0[0], wd0[1]} !== {16'h1234, 16'hABCD}) begin
                errors++;
                $display("FAIL start_ignored_data: got %h %h, want 1234 abcd", wd0[0], wd0[1]);
            end
        end
    endtask

    task automatic test_reset_midload();
        clear_q();
        do_start();
        send_byte(8'h01);
        send_byte(8'h55);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({in_ready0, mem_we0, mem_addr0, mem_wdata0, cpu_hold0, load_done0, load_err0} !== 29'd0) begin
            errors++;
            $display("FAIL async_reset: got rdy=%b we=%b addr=%h wd=%h hold=%b done=%b err=%b, want all 0",
                     in_ready0, mem_we0, mem_addr0, mem_wdata0, cpu_hold0, load_done0, load_err0);
        end
        tick();
        tick();
        reset = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h66;
        repeat (4) tick();
        checks++;
        if ({in_ready0, cpu_hold0, mem_we0} !== 3'b000 || wa0.size() !== 0) begin
            errors++;
            $display("FAIL reset_idle: got rdy=%b hold=%b we=%b writes=%0d, want 000 and 0",
                     in_ready0, cpu_hold0, mem_we0, wa0.size());
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_ok();
        test_bad_csum();
        test_wrap();
        test_n0();
        test_timeout();
        test_start_ignored();
        test_reset_midload();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
